// File: rtl/mac_shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mac_shift_add_multiplier_pkg
//  Brief  : Shared definitions for the MAC shift-and-add multiplier stage.
//           Holds the FSM state encoding and the default operand width,
//           which is also used by the downstream accumulate stage.
//  Rev    : 1.0  initial release
// ============================================================================
package mac_shift_add_multiplier_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_WIDTH_DEFAULT = 8;

  // Multiplier FSM state encoding.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage : mac_shift_add_multiplier_pkg
`default_nettype wire

// File: rtl/mac_shift_add_multiplier_adder_8_bit.sv
`default_nettype none
// ============================================================================
//  Module : adder_8_bit
//  Brief  : Unsigned ripple-carry adder with carry out, used for the
//           per-step partial-product add of the shift-and-add multiplier.
//  Ports  : a_i[WIDTH-1:0]   addend (running high half of the product)
//           b_i[WIDTH-1:0]   addend (gated multiplicand)
//           sum_o[WIDTH-1:0] a_i + b_i, low WIDTH bits
//           carry_o          carry out of the most significant bit
//  Rev    : 1.0  initial release
// ============================================================================
module adder_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Carry chain: w_carry[i] is the carry into bit i.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i]       = a_i[i] ^ b_i[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = w_carry[WIDTH];

endmodule : adder_8_bit
`default_nettype wire

// File: rtl/mac_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module : mac_shift_add_multiplier
//  Brief  : Sequential unsigned WIDTH x WIDTH shift-and-add multiplier feeding
//           the MAC accumulate adder. One operand pair is accepted per
//           valid/ready handshake, one partial-product bit is processed per
//           cycle, and the 2*WIDTH-bit product is offered via valid/ready.
//           Only one multiply is in flight at a time.
//  Ports  : clk                    clock, rising edge
//           rst                    synchronous active-high reset
//           in_valid / in_ready    operand handshake
//           a[WIDTH-1:0]           multiplicand, unsigned
//           b[WIDTH-1:0]           multiplier, unsigned
//           out_valid / out_ready  product handshake
//           product[2*WIDTH-1:0]   a*b, unsigned, exact
//  Rev    : 1.0  initial release
// ============================================================================
module mac_shift_add_multiplier
  import mac_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mul_state_e         state_q,     state_d;
  logic [WIDTH-1:0]   mcand_q,     mcand_d;
  logic [2*WIDTH-1:0] p_q,         p_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic [2*WIDTH-1:0] product_q,   product_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [2*WIDTH-1:0] w_p_shifted;

  // Partial-product add: high half plus the multiplicand when the current
  // multiplier bit (LSB of P) is set.
  assign w_addend = p_q[0] ? mcand_q : '0;

  adder_8_bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i     (p_q[2*WIDTH-1:WIDTH]),
    .b_i     (w_addend),
    .sum_o   (w_sum),
    .carry_o (w_carry)
  );

  // The carry becomes the new MSB as the whole register shifts right, so the
  // consumed multiplier bit drops out of the bottom and nothing is lost.
  assign w_p_shifted = {w_carry, w_sum, p_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    p_d         = p_q;
    count_d     = count_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      MUL_IDLE: begin
        if (in_valid) begin
          state_d = MUL_BUSY;
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          count_d = '0;
        end
      end
      MUL_BUSY: begin
        p_d     = w_p_shifted;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          state_d     = MUL_DONE;
          product_d   = w_p_shifted;
          out_valid_d = 1'b1;
        end
      end
      MUL_DONE: begin
        // Product stays put after the drain; only out_valid falls.
        if (out_ready) begin
          state_d     = MUL_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = MUL_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MUL_IDLE;
      mcand_q     <= '0;
      p_q         <= '0;
      count_q     <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      p_q         <= p_d;
      count_q     <= count_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == MUL_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule : mac_shift_add_multiplier
`default_nettype wire

// File: tb/tb_mac_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module : tb_mac_shift_add_multiplier
//  Brief  : Self-checking bench for mac_shift_add_multiplier. Directed cases
//           plus random operand pairs with random backpressure, checked
//           against plain a*b arithmetic and a fixed 8-cycle latency.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_mac_shift_add_multiplier;

  localparam int W       = 8;
  localparam int LATENCY = W;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int n_cmp;
  int n_mis;

  mac_shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one pair (inputs changed at a negedge), wait for the product,
  // hold off the consumer for 'hold' cycles, then drain it.
  task automatic do_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int hold);
    logic [2*W-1:0] exp_p;
    int             cyc;
    exp_p     = {{W{1'b0}}, ta} * {{W{1'b0}}, tb_};
    out_ready = (hold == 0);
    check("ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_;
    @(negedge clk);
    // Operand changes after the accept edge must not matter.
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    cyc       = 1;
    check("busy_not_ready", in_ready, 0);
    while (!out_valid && cyc < 3 * LATENCY) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc - 1, LATENCY);
    check("product", product, exp_p);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_product", product, exp_p);
      check("hold_not_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drained_valid", out_valid, 0);
    check("drained_ready", in_ready, 1);
    check("drained_product", product, exp_p);
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    do_mul(8'hFF, 8'hFF, 0);
    check("ff_x_ff", product, 16'hFE01);
    do_mul(8'h0D, 8'h0B, 0);
    check("0d_x_0b", product, 16'h008F);
    do_mul(8'h00, 8'hFF, 0);
    do_mul(8'hA5, 8'h01, 0);
    check("a5_x_01", product, 16'h00A5);
    do_mul(8'h80, 8'h02, 5);
    check("80_x_02", product, 16'h0100);
    // Next pair goes straight in on the cycle after the drain.
    do_mul(8'h07, 8'h09, 0);

    // Reset in the middle of a multiply: no product may appear.
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_product", product, 16'h0000);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 2 * LATENCY; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_output", seen, 0);
    end
    do_mul(8'h03, 8'h05, 0);
    check("03_x_05", product, 16'h000F);

    for (int n = 0; n < 20; n++) begin
      do_mul(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_mac_shift_add_multiplier
`default_nettype wire
